// File: rtl/keypad_if.sv
// Keypad-side bundle: column sense into the scanner, row drive and decoded key out.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col,
    output row,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output col,
    input  row,
    input  key,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, debounces press and release of a
// single key and strobes its hex code for one cycle on each accepted press.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES + 1) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [SCAN_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        col_pat_q, col_pat_d;
  logic [1:0]        col_bit_q, col_bit_d;
  logic [3:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic [3:0]        row_q, row_d;

  logic [DEB_W-1:0]  cnt_inc;
  logic              cnt_done;
  logic              dwell_last;
  logic              latched_released;

  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign cnt_inc          = cnt_q + DEB_W'(1);
  assign cnt_done         = (cnt_inc == DEB_W'(DEBOUNCE_CYCLES));
  assign dwell_last       = (dwell_q == SCAN_W'(SCAN_CYCLES - 1));
  assign latched_released = kp.col[col_bit_q];

  // Counts only advance on a qualifying sample; any break restarts them from zero.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    col_pat_d   = col_pat_q;
    col_bit_d   = col_bit_q;
    key_d       = key_q;
    key_valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (dwell_last) begin
          dwell_d = '0;
          if ($onehot(~kp.col)) begin
            col_pat_d = kp.col;
            col_bit_d = col_index(kp.col);
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + SCAN_W'(1);
        end
      end

      DEBOUNCE: begin
        if (kp.col == col_pat_q) begin
          if (cnt_done) begin
            key_d       = key_lookup(row_idx_q, col_bit_q);
            key_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d     = '0;
          dwell_d   = '0;
          row_idx_d = row_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      HELD: begin
        if (latched_released) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (!latched_released) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_done) begin
          cnt_d     = '0;
          dwell_d   = '0;
          row_idx_d = row_idx_q + 2'd1;
          state_d   = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    key_held_d = (state_d == HELD) || (state_d == RELEASE);
    row_d      = ~(4'b0001 << row_idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      col_pat_q   <= 4'b1111;
      col_bit_q   <= 2'd0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      row_q       <= 4'b1110;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      col_pat_q   <= col_pat_d;
      col_bit_q   <= col_bit_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      row_q       <= row_d;
    end
  end

  assign kp.row       = row_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
